// File: rtl/load_use_stall_if.sv
// Decode-side hazard bundle: ID operand fields, EX/MEM producer info, flush in;
// PC / IF-ID / ID-EX stall controls out.
interface load_use_stall_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_store;
    logic       id_is_branch;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_to_reg;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic       mem_mem_to_reg;
    logic       flush;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_flush;
    logic       stall_active;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store, id_is_branch,
               ex_rd, ex_reg_write, ex_mem_to_reg,
               mem_rd, mem_reg_write, mem_mem_to_reg, flush,
        input  pc_write, ifid_write, idex_flush, stall_active
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store, id_is_branch,
               ex_rd, ex_reg_write, ex_mem_to_reg,
               mem_rd, mem_reg_write, mem_mem_to_reg, flush,
        output pc_write, ifid_write, idex_flush, stall_active
    );
endinterface

// File: rtl/load_use_stall.sv
// Load-use / branch-operand hazard detection with zero-latency stall insertion.
// Optional saturating stall-cycle counter enabled by HAZARD_STATS_EN.
module load_use_stall #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    load_use_stall_if.slave    bus,
    output logic [COUNT_W-1:0] stall_count
);
    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        STALL_LAST = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   stall_s;
    logic   rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
    logic   h1_s, h2_s;

    // Operand matches against EX and MEM producers; $0 never creates a dependency.
    always_comb begin
        rs_ex_s  = bus.id_uses_rs & (bus.ex_rd  == bus.id_rs) & (bus.ex_rd  != 5'd0);
        rt_ex_s  = bus.id_uses_rt & (bus.ex_rd  == bus.id_rt) & (bus.ex_rd  != 5'd0);
        rs_mem_s = bus.id_uses_rs & (bus.mem_rd == bus.id_rs) & (bus.mem_rd != 5'd0);
        rt_mem_s = bus.id_uses_rt & (bus.mem_rd == bus.id_rt) & (bus.mem_rd != 5'd0);
    end

    // Hazard classes; a store's rt match is left to MEM-stage store-data forwarding.
    always_comb begin
        h2_s = bus.id_is_branch & bus.ex_reg_write & bus.ex_mem_to_reg & (rs_ex_s | rt_ex_s);
        h1_s = (~bus.id_is_branch & bus.ex_mem_to_reg & bus.ex_reg_write &
                (rs_ex_s | (rt_ex_s & ~bus.id_is_store)))
             | (bus.id_is_branch &
                ((bus.ex_reg_write & ~bus.ex_mem_to_reg & (rs_ex_s | rt_ex_s)) |
                 (bus.mem_reg_write & bus.mem_mem_to_reg & (rs_mem_s | rt_mem_s))));
    end

    // Next state and stall decision; reset and flush both force non-stall outputs.
    always_comb begin
        state_d = IDLE;
        stall_s = 1'b0;
        if (reset || bus.flush) begin
            state_d = IDLE;
            stall_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (h2_s) begin
                        stall_s = 1'b1;
                        state_d = STALL_LAST;
                    end else if (h1_s) begin
                        stall_s = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall_s = 1'b0;
                        state_d = IDLE;
                    end
                end
                STALL_LAST: begin
                    stall_s = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    stall_s = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_write     = ~stall_s;
    assign bus.ifid_write   = ~stall_s;
    assign bus.idex_flush   = stall_s;
    assign bus.stall_active = stall_s;

`ifdef HAZARD_STATS_EN
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Saturating stall-cycle count; holds at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (stall_s && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {COUNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign stall_count = count_q;
`else
    assign stall_count = {COUNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_load_use_stall.sv
// Directed bench for load_use_stall: hazard classes, store exemption, $0, flush,
// reset abort and counter saturation (COUNT_W=2).
module tb_load_use_stall;
    localparam int COUNT_W = 2;

    logic               clk;
    logic               reset;
    logic [COUNT_W-1:0] stall_count;
    int                 passed;
    int                 total;
    int                 exp_cnt;

    load_use_stall_if bus ();

    load_use_stall #(.COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.id_rs          = 5'd0;
        bus.id_rt          = 5'd0;
        bus.id_uses_rs     = 1'b0;
        bus.id_uses_rt     = 1'b0;
        bus.id_is_store    = 1'b0;
        bus.id_is_branch   = 1'b0;
        bus.ex_rd          = 5'd0;
        bus.ex_reg_write   = 1'b0;
        bus.ex_mem_to_reg  = 1'b0;
        bus.mem_rd         = 5'd0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_mem_to_reg = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic ex_load(input logic [4:0] rd);
        bus.ex_rd         = rd;
        bus.ex_reg_write  = 1'b1;
        bus.ex_mem_to_reg = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One cycle: check combinational stall outputs and the counter, then advance.
    task automatic cyc(input string tag, input bit exp_stall);
        logic [3:0] exp_out;
        logic [3:0] exp_sc;
        #1;
        exp_out = exp_stall ? 4'b0011 : 4'b1100;
        chk({tag, "/out"},
            {bus.pc_write, bus.ifid_write, bus.idex_flush, bus.stall_active}, exp_out);
`ifdef HAZARD_STATS_EN
        exp_sc = 4'(exp_cnt);
`else
        exp_sc = 4'd0;
`endif
        chk({tag, "/cnt"}, {2'b00, stall_count}, exp_sc);
        if (reset) begin
            exp_cnt = 0;
        end else if (exp_stall && exp_cnt < 3) begin
            exp_cnt = exp_cnt + 1;
        end
        @(negedge clk);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Reset holds outputs non-stall even with a live load-use hazard.
        ex_load(5'd5);
        bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        cyc("rst_hold", 1'b0);
        reset = 1'b0;

        // lw $5 ; add reading $5 -> one bubble, then EX holds the bubble.
        cyc("h1_add", 1'b1);
        bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_to_reg = 1'b0;
        cyc("h1_after", 1'b0);

        // lw $5 ; sw with rt=5 forwarded, then address rs=5 stalls.
        ex_load(5'd5);
        bus.id_is_store = 1'b1;
        bus.id_rs = 5'd2; bus.id_uses_rs = 1'b1;
        bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
        cyc("sw_rt", 1'b0);
        bus.id_rs = 5'd5;
        cyc("sw_rs", 1'b1);
        clear_inputs();
        cyc("idle1", 1'b0);
        reset = 1'b1;
        cyc("rst2", 1'b0);
        reset = 1'b0;

        // lw $7 ; beq on $7 -> exactly two bubbles even if EX changes.
        ex_load(5'd7);
        bus.id_is_branch = 1'b1;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
        bus.id_rt = 5'd1; bus.id_uses_rt = 1'b1;
        cyc("h2_c1", 1'b1);
        bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_to_reg = 1'b0;
        cyc("h2_c2", 1'b1);
        clear_inputs();
        cyc("h2_done", 1'b0);
        reset = 1'b1;
        cyc("rst3", 1'b0);
        reset = 1'b0;

        // add writing $3 in EX ; bne on rt=3 -> one bubble. Load in MEM vs branch -> one.
        bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1;
        bus.id_is_branch = 1'b1;
        bus.id_rt = 5'd3; bus.id_uses_rt = 1'b1;
        cyc("h1_br_ex", 1'b1);
        clear_inputs();
        bus.mem_rd = 5'd4; bus.mem_reg_write = 1'b1; bus.mem_mem_to_reg = 1'b1;
        bus.id_is_branch = 1'b1;
        bus.id_rs = 5'd4; bus.id_uses_rs = 1'b1;
        cyc("h1_br_mem", 1'b1);
        clear_inputs();
        cyc("idle2", 1'b0);

        // $0 is never a hazard source.
        ex_load(5'd0);
        bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        cyc("zero_reg", 1'b0);

        // H2 then flush in the STALL_LAST cycle -> non-stall, back to IDLE.
        clear_inputs();
        ex_load(5'd7);
        bus.id_is_branch = 1'b1;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
        cyc("fl_c1", 1'b1);
        bus.flush = 1'b1;
        cyc("fl_c2", 1'b0);
        clear_inputs();
        cyc("fl_after", 1'b0);

        // Flush while an H2 hazard appears in IDLE: no stall, no STALL_LAST.
        ex_load(5'd7);
        bus.id_is_branch = 1'b1;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
        bus.flush = 1'b1;
        cyc("fl_idle", 1'b0);
        clear_inputs();
        cyc("fl_idle_after", 1'b0);

        // H2 then reset in the second cycle aborts the stall and clears the count.
        ex_load(5'd7);
        bus.id_is_branch = 1'b1;
        bus.id_rs = 5'd7; bus.id_uses_rs = 1'b1;
        cyc("rs_c1", 1'b1);
        reset = 1'b1;
        cyc("rs_c2", 1'b0);
        reset = 1'b0;
        clear_inputs();
        cyc("rs_after", 1'b0);

        // Five consecutive H1 stall cycles saturate a 2-bit counter at 3.
        ex_load(5'd5);
        bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc("sat", 1'b1);
        end
        clear_inputs();
        cyc("sat_end", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_use_stall.md
# load_use_stall

Hazard-detection and stall controller for the 5-stage MIPS pipeline; the decode-side counterpart of the MEM-stage lw→sw store-data forwarding path. It compares the instruction in ID against the producers in EX and MEM. On a load-use or branch-operand hazard it freezes PC and IF/ID and injects bubbles into ID/EX for exactly the required number of cycles. Dependencies that the store-data forwarding path already resolves are deliberately not stalled.

## Interface
- COUNT_W, 16, width of the stall-cycle statistics counter
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- id_rs, id_rt  input  5  source register fields of the instruction in ID
- id_uses_rs, id_uses_rt  input  1  ID instruction actually reads rs / rt
- id_is_store  input  1  ID instruction is sw (rt is store data only)
- id_is_branch  input  1  ID instruction is beq/bne (compares in ID)
- ex_rd  input  5  destination register of the instruction in EX
- ex_reg_write, ex_mem_to_reg  input  1  EX instruction writes a register / is a load
- mem_rd  input  5  destination register of the instruction in MEM
- mem_reg_write, mem_mem_to_reg  input  1  MEM instruction writes a register / is a load
- flush  input  1  taken-branch/jump flush of IF/ID this cycle
- pc_write  output  1  0 = hold PC
- ifid_write  output  1  0 = hold IF/ID
- idex_flush  output  1  1 = load a bubble (all controls 0) into ID/EX
- stall_active  output  1  stall in progress (equals idex_flush)
- stall_count  output  COUNT_W  saturating count of stall cycles (macro-gated)

## Operation
- Register $0 is never a hazard source: any match with ex_rd==0 or mem_rd==0 is ignored.
- rs_ex = id_uses_rs & ex_rd==id_rs; rt_ex = id_uses_rt & ex_rd==id_rt; rs_mem and rt_mem are formed the same way against mem_rd.
- The store-data exemption applies only to non-branch instructions. When id_is_store=1, a match on rt alone does not stall, because forwarding supplies the store data in MEM. A match on rs (the address) always counts.
- Hazard classes, evaluated only in state IDLE:
  - H2: id_is_branch & ex_reg_write & ex_mem_to_reg & (rs_ex|rt_ex). Two bubbles.
  - H1, non-branch: ex_mem_to_reg & ex_reg_write & (rs_ex | (rt_ex & ~id_is_store)). One bubble.
  - H1, branch: id_is_branch & ((ex_reg_write & ~ex_mem_to_reg & (rs_ex|rt_ex)) | (mem_reg_write & mem_mem_to_reg & (rs_mem|rt_mem))). One bubble.
  - H2 has priority over H1.
- FSM states: IDLE, STALL_LAST.
  - IDLE with H1: stall this cycle; next state IDLE. The hazard is re-evaluated next cycle.
  - IDLE with H2: stall this cycle; next state STALL_LAST.
  - STALL_LAST: stall unconditionally, ignore hazard inputs; next state IDLE.
- While stalling: pc_write=0, ifid_write=0, idex_flush=1, stall_active=1. Otherwise pc_write=1, ifid_write=1, idex_flush=0, stall_active=0.
- flush=1 has priority over everything. Outputs go to the non-stall values that cycle, the next state is IDLE, and the instruction in ID is discarded. This applies in any state.

## Timing
- Stall outputs are combinational from the current state and inputs. Detection and the first bubble occur in the same cycle, with zero latency.
- Bubble count per hazard: H1 = 1 cycle, H2 = exactly 2 consecutive cycles.
- State update on the rising edge of clk.
- Reset: state = IDLE, stall_count = 0. While reset=1 the outputs are pc_write=1, ifid_write=1, idex_flush=0, stall_active=0, regardless of the hazard inputs.
- Reset asserted during STALL_LAST aborts the stall; the next cycle starts in IDLE.
- stall_count increments by 1 on every cycle with stall_active=1. It saturates at 2^COUNT_W−1 and never wraps.

## Configuration
- HAZARD_STATS_EN defined: stall_count is implemented as specified.
- HAZARD_STATS_EN undefined: no counter register; stall_count is tied to 0.
- Stall behaviour is identical either way.

## Test plan
- EX: lw $5 (ex_rd=5, ex_mem_to_reg=1, ex_reg_write=1); ID: add reading rs=5 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; then, with EX holding the bubble, no stall; stall_count=1.
- EX: lw $5; ID: sw, rt=5, rs=2, id_is_store=1 → no stall. The same case with rs=5 → one-cycle stall.
- EX: lw $7; ID: beq on rs=7 → stall exactly 2 cycles (IDLE→STALL_LAST→IDLE) even if the EX inputs change in cycle 2; stall_count=2.
- EX: add writing $3; ID: bne on rt=3 → 1 bubble. A separate case with ex_rd=0 and a matching $0 read → no stall.
- H2 detected, then flush=1 in the STALL_LAST cycle → outputs non-stall that cycle, next state IDLE.
- H2 detected, then reset=1 in the second cycle → outputs non-stall, stall_count=0 next cycle.
- With HAZARD_STATS_EN and COUNT_W=2: 5 stall cycles → stall_count saturates at 3.
